// File: rtl/oam_dma_controller_pkg.sv
// Shared definitions for the Game Boy memory-map blocks that touch OAM DMA.
//   DMA_REG_ADDR : CPU address of the DMA source/trigger register (FF46)
//   OAM_LEN      : number of bytes copied into OAM per transfer
//   dma_state_t  : per-slot sequencing states of the DMA engine
//   echo_fold()  : maps echo-RAM source pages E0..FF onto C0..DF
package gb_mem_pkg;

   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam int          OAM_LEN      = 160;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      WRITE,
      HOLD
   } dma_state_t;

   // E0..FF is an alias of C0..DF; clearing bit 5 folds it back.
   function automatic logic [7:0] echo_fold(input logic [7:0] src);
      return (src >= 8'hE0) ? (src & 8'hDF) : src;
   endfunction

endpackage

// File: rtl/oam_dma_controller_if.sv
// Bus bundle between the OAM DMA engine and the memory map.
//   CPU side : cpu_addr/cpu_wren/cpu_data_in in, reg_hit/reg_data_out back
//   Source   : dma_addr/dma_rd_en out, mem_data_in back (1-cycle latency)
//   OAM      : oam_addr/oam_data/oam_wren out
//   Status   : dma_active (memory map blocks CPU), dma_done pulse
// modport master : the DMA engine (drives the source read and OAM write ports)
// modport slave  : the memory map side
interface oam_dma_controller_if;

   logic [15:0] cpu_addr;
   logic        cpu_wren;
   logic [7:0]  cpu_data_in;
   logic        reg_hit;
   logic [7:0]  reg_data_out;
   logic        dma_active;
   logic [15:0] dma_addr;
   logic        dma_rd_en;
   logic [7:0]  mem_data_in;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_data;
   logic        oam_wren;
   logic        dma_done;

   modport master (
      input  cpu_addr, cpu_wren, cpu_data_in, mem_data_in,
      output reg_hit, reg_data_out, dma_active, dma_addr, dma_rd_en,
             oam_addr, oam_data, oam_wren, dma_done
   );

   modport slave (
      output cpu_addr, cpu_wren, cpu_data_in, mem_data_in,
      input  reg_hit, reg_data_out, dma_active, dma_addr, dma_rd_en,
             oam_addr, oam_data, oam_wren, dma_done
   );

endinterface

// File: rtl/oam_dma_controller.sv
// Game Boy OAM DMA engine (register FF46).
// A CPU write to FF46 copies OAM_LEN bytes from {src,00..} into OAM 00...
// Each byte takes one slot of BYTE_CYCLES clocks: READ, CAPTURE, WRITE, HOLD*.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   bus            : oam_dma_controller_if.master (CPU reg, source read, OAM write)
// All bus outputs are registered except reg_hit, which is a pure address decode.
module oam_dma_controller #(
   parameter int BYTE_CYCLES = 4,
   parameter int OAM_LEN     = gb_mem_pkg::OAM_LEN
) (
   input  logic                    clock,
   input  logic                    reset_n,
   oam_dma_controller_if.master    bus
);
   import gb_mem_pkg::*;

   localparam logic [3:0] SLOT_LAST = 4'(BYTE_CYCLES - 1);
   localparam logic [7:0] IDX_LAST  = 8'(OAM_LEN - 1);

   dma_state_t  state_q;
   logic [7:0]  src_q;
   logic [7:0]  eff_q;
   logic [7:0]  idx_q;
   logic [3:0]  slot_q;
   logic        active_q;
   logic        rd_en_q;
   logic [15:0] dma_addr_q;
   logic [7:0]  oam_addr_q;
   logic [7:0]  oam_data_q;
   logic        oam_wren_q;
   logic        done_q;
   logic        trig;

   assign bus.reg_hit = (bus.cpu_addr == DMA_REG_ADDR);
   assign trig        = bus.cpu_wren && bus.reg_hit;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         src_q      <= 8'hFF;
         eff_q      <= 8'hDF;
         idx_q      <= 8'h00;
         slot_q     <= 4'h0;
         active_q   <= 1'b0;
         rd_en_q    <= 1'b0;
         dma_addr_q <= 16'h0000;
         oam_addr_q <= 8'h00;
         oam_data_q <= 8'h00;
         oam_wren_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (trig) begin
            // (Re)start always wins, including over the final slot end, so a
            // restart never emits dma_done and never drops dma_active.
            src_q      <= bus.cpu_data_in;
            eff_q      <= echo_fold(bus.cpu_data_in);
            state_q    <= READ;
            idx_q      <= 8'h00;
            slot_q     <= 4'h0;
            active_q   <= 1'b1;
            rd_en_q    <= 1'b1;
            dma_addr_q <= {echo_fold(bus.cpu_data_in), 8'h00};
            oam_wren_q <= 1'b0;
         end else if (state_q != IDLE) begin
            slot_q <= slot_q + 4'd1;
            unique case (state_q)
               READ: begin
                  state_q <= CAPTURE;
                  rd_en_q <= 1'b0;
               end
               CAPTURE: begin
                  // Source data is valid this cycle; it becomes the OAM write data.
                  state_q    <= WRITE;
                  oam_wren_q <= 1'b1;
                  oam_addr_q <= idx_q;
                  oam_data_q <= bus.mem_data_in;
               end
               WRITE: begin
                  state_q    <= HOLD;
                  oam_wren_q <= 1'b0;
               end
               default: ;
            endcase
            // Slot end overrides the per-state next state above (covers
            // BYTE_CYCLES == 3, where WRITE is the last cycle of the slot).
            if (slot_q == SLOT_LAST) begin
               slot_q <= 4'h0;
               if (idx_q < IDX_LAST) begin
                  idx_q      <= idx_q + 8'd1;
                  state_q    <= READ;
                  rd_en_q    <= 1'b1;
                  dma_addr_q <= {eff_q, idx_q + 8'd1};
               end else begin
                  idx_q    <= 8'h00;
                  state_q  <= IDLE;
                  active_q <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
         end
      end
   end

   assign bus.reg_data_out = src_q;
   assign bus.dma_active   = active_q;
   assign bus.dma_addr     = dma_addr_q;
   assign bus.dma_rd_en    = rd_en_q;
   assign bus.oam_addr     = oam_addr_q;
   assign bus.oam_data     = oam_data_q;
   assign bus.oam_wren     = oam_wren_q;
   assign bus.dma_done     = done_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: basic copy, echo alias, restart,
// async reset mid-transfer, final-slot collision, non-trigger addresses.
module tb_oam_dma_controller;

   logic clock;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   oam_dma_controller_if bus();

   oam_dma_controller #(.BYTE_CYCLES(4), .OAM_LEN(160)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous source memory: returns the low address byte one cycle later.
   always @(posedge clock) if (bus.dma_rd_en) bus.mem_data_in <= bus.dma_addr[7:0];

   // Event logs sampled on the falling edge.
   int          cyc = 0, wr_cnt = 0, rd_cnt = 0, act_cnt = 0, done_cnt = 0, rise_cnt = 0;
   logic        act_prev = 1'b0;
   logic [7:0]  wr_addr_log [0:4095];
   logic [7:0]  wr_data_log [0:4095];
   int          wr_cyc_log  [0:4095];
   logic [15:0] rd_addr_log [0:4095];
   int          rd_cyc_log  [0:4095];

   always @(negedge clock) begin
      cyc = cyc + 1;
      if (bus.dma_active === 1'b1) act_cnt = act_cnt + 1;
      if (bus.dma_active === 1'b1 && act_prev !== 1'b1) rise_cnt = rise_cnt + 1;
      act_prev = bus.dma_active;
      if (bus.dma_done === 1'b1) done_cnt = done_cnt + 1;
      if (bus.oam_wren === 1'b1 && wr_cnt < 4096) begin
         wr_addr_log[wr_cnt] = bus.oam_addr;
         wr_data_log[wr_cnt] = bus.oam_data;
         wr_cyc_log[wr_cnt]  = cyc;
         wr_cnt = wr_cnt + 1;
      end
      if (bus.dma_rd_en === 1'b1 && rd_cnt < 4096) begin
         rd_addr_log[rd_cnt] = bus.dma_addr;
         rd_cyc_log[rd_cnt]  = cyc;
         rd_cnt = rd_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Move to just after the falling edge, well clear of the active edge.
   task automatic step(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      step(1);
      bus.cpu_addr = a; bus.cpu_data_in = d; bus.cpu_wren = 1'b1;
      step(1);
      bus.cpu_wren = 1'b0; bus.cpu_addr = 16'h0000;
   endtask

   task automatic wait_writes(input int base, input int n, input string tag);
      int guard;
      guard = 0;
      while (wr_cnt - base < n && guard < 2000) begin
         step(1);
         guard++;
      end
      chk(tag, 32'(guard < 2000), 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_active"}, 32'(bus.dma_active), 32'd0);
      chk({tag, "_rd_en"},  32'(bus.dma_rd_en),  32'd0);
      chk({tag, "_wren"},   32'(bus.oam_wren),   32'd0);
      chk({tag, "_done"},   32'(bus.dma_done),   32'd0);
      chk({tag, "_daddr"},  32'(bus.dma_addr),   32'h0);
      chk({tag, "_oaddr"},  32'(bus.oam_addr),   32'h0);
      chk({tag, "_odata"},  32'(bus.oam_data),   32'h0);
      chk({tag, "_reg"},    32'(bus.reg_data_out), 32'hFF);
   endtask

   initial begin
      int w0, r0, a0, d0, s0, bad;
      bus.cpu_addr = 16'h0000; bus.cpu_wren = 1'b0; bus.cpu_data_in = 8'h00;
      bus.mem_data_in = 8'h00;
      reset_n = 1'b0;
      step(3);
      chk_reset_outputs("reset");
      reset_n = 1'b1;
      step(2);

      // Basic transfer from C000.
      w0 = wr_cnt; r0 = rd_cnt; a0 = act_cnt; d0 = done_cnt; s0 = rise_cnt;
      cpu_write(16'hFF46, 8'hC0);
      chk("basic_start_active", 32'(bus.dma_active), 32'd1);
      chk("basic_start_addr", 32'(bus.dma_addr), 32'hC000);
      chk("basic_reg", 32'(bus.reg_data_out), 32'hC0);
      step(660);
      chk("basic_writes", 32'(wr_cnt - w0), 32'd160);
      chk("basic_active_cycles", 32'(act_cnt - a0), 32'd640);
      chk("basic_done", 32'(done_cnt - d0), 32'd1);
      chk("basic_first_wr_lat", 32'(wr_cyc_log[w0] - rd_cyc_log[r0]), 32'd2);
      bad = 0;
      for (int i = 0; i < 160; i++) begin
         if (wr_addr_log[w0+i] !== 8'(i) || wr_data_log[w0+i] !== 8'(i)) bad++;
         if (i > 0 && wr_cyc_log[w0+i] - wr_cyc_log[w0+i-1] != 4) bad++;
      end
      chk("basic_wr_sequence", 32'(bad), 32'd0);

      // Echo alias: E1 reads from C1xx.
      r0 = rd_cnt; d0 = done_cnt;
      cpu_write(16'hFF46, 8'hE1);
      chk("echo_reg", 32'(bus.reg_data_out), 32'hE1);
      step(660);
      chk("echo_reads", 32'(rd_cnt - r0), 32'd160);
      bad = 0;
      for (int i = 0; i < 160; i++)
         if (rd_addr_log[r0+i] !== (16'hC100 + 16'(i))) bad++;
      chk("echo_rd_sequence", 32'(bad), 32'd0);
      chk("echo_done", 32'(done_cnt - d0), 32'd1);

      // Restart at byte 50 with source 80.
      w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; s0 = rise_cnt;
      cpu_write(16'hFF46, 8'hC0);
      wait_writes(w0, 50, "restart_wait");
      cpu_write(16'hFF46, 8'h80);
      chk("restart_addr", 32'(bus.dma_addr), 32'h8000);
      chk("restart_rd_en", 32'(bus.dma_rd_en), 32'd1);
      chk("restart_no_done_yet", 32'(done_cnt - d0), 32'd0);
      step(700);
      chk("restart_rises", 32'(rise_cnt - s0), 32'd1);
      chk("restart_done", 32'(done_cnt - d0), 32'd1);
      chk("restart_writes", 32'(wr_cnt - w0), 32'd210);
      chk("restart_pre_last", 32'(wr_addr_log[w0+49]), 32'd49);
      chk("restart_first_new", 32'(wr_addr_log[w0+50]), 32'd0);
      chk("restart_last", 32'(wr_addr_log[w0+209]), 32'd159);
      chk("restart_first_read", 32'(rd_addr_log[r0+50]), 32'h8000);

      // Asynchronous reset at byte 20.
      w0 = wr_cnt; d0 = done_cnt;
      cpu_write(16'hFF46, 8'hC0);
      wait_writes(w0, 20, "rst_wait");
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("midrst");
      step(2);
      reset_n = 1'b1;
      step(50);
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("midrst_idle", 32'(bus.dma_active), 32'd0);

      // FF46 write coinciding with the final slot end.
      w0 = wr_cnt; d0 = done_cnt; s0 = rise_cnt;
      cpu_write(16'hFF46, 8'hC0);
      wait_writes(w0, 160, "coll_wait");
      cpu_write(16'hFF46, 8'h90);
      chk("coll_no_done", 32'(done_cnt - d0), 32'd0);
      chk("coll_active", 32'(bus.dma_active), 32'd1);
      chk("coll_addr", 32'(bus.dma_addr), 32'h9000);
      step(660);
      chk("coll_done_once", 32'(done_cnt - d0), 32'd1);
      chk("coll_rises", 32'(rise_cnt - s0), 32'd1);
      chk("coll_writes", 32'(wr_cnt - w0), 32'd320);

      // Neighbouring registers start nothing; FF46 reads back last value.
      r0 = rd_cnt; s0 = rise_cnt;
      cpu_write(16'hFF45, 8'h12);
      cpu_write(16'hFF47, 8'h34);
      step(10);
      chk("nontrig_reads", 32'(rd_cnt - r0), 32'd0);
      chk("nontrig_rises", 32'(rise_cnt - s0), 32'd0);
      bus.cpu_addr = 16'hFF46;
      #1;
      chk("read_hit", 32'(bus.reg_hit), 32'd1);
      chk("read_value", 32'(bus.reg_data_out), 32'h90);
      bus.cpu_addr = 16'hFF47;
      #1;
      chk("miss_hit", 32'(bus.reg_hit), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
